// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states,
// iterative-engine modes and status-flag bit positions.
package alu_pkg;

  localparam logic [4:0] OP_LD  = 5'h01;
  localparam logic [4:0] OP_ST  = 5'h02;
  localparam logic [4:0] OP_ADD = 5'h03;
  localparam logic [4:0] OP_SUB = 5'h04;
  localparam logic [4:0] OP_AND = 5'h05;
  localparam logic [4:0] OP_OR  = 5'h06;
  localparam logic [4:0] OP_XOR = 5'h07;
  localparam logic [4:0] OP_NOT = 5'h08;
  localparam logic [4:0] OP_SL  = 5'h09;
  localparam logic [4:0] OP_SR  = 5'h0A;
  localparam logic [4:0] OP_MUL = 5'h0B;
  localparam logic [4:0] OP_CMP = 5'h0C;
  localparam logic [4:0] OP_BZ  = 5'h10;
  localparam logic [4:0] OP_BNZ = 5'h11;
  localparam logic [4:0] OP_BRA = 5'h12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    IT_SHL,
    IT_SHR,
    IT_MUL
  } iter_mode_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_H = 4;
  localparam int NFLAGS = 5;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative engine: one-bit-per-cycle logical shifter and unsigned
// shift-add multiplier. Exposes the value of the step in flight so the
// caller can commit the final step on the same edge it happens.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  iter_mode_e                    mode,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  input  logic [$clog2(WIDTH):0]        amt,
  output logic                          last,
  output logic [WIDTH-1:0]              res_step,
  output logic                          cout_step,
  output logic                          half_bit,
  output logic                          hi_nz
);

  localparam int SHW = $clog2(WIDTH) + 1;
  localparam int HB  = WIDTH / 2;

  logic [2*WIDTH-1:0] d_q;
  logic [2*WIDTH-1:0] d_step;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH:0]     madd;
  logic [SHW-1:0]     cnt_q;
  logic               busy_q;
  iter_mode_e         mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      mode_q <= IT_SHL;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= amt;
      mode_q <= mode;
    end else if (busy_q) begin
      cnt_q <= cnt_q - SHW'(1);
      if (cnt_q == SHW'(1)) busy_q <= 1'b0;
    end
  end

  // Multiplier layout: upper half = partial product, lower half = multiplier bits
  always_ff @(posedge clk) begin
    if (start) begin
      d_q     <= (mode == IT_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
      mcand_q <= a;
    end else if (busy_q) begin
      d_q <= d_step;
    end
  end

  always_comb begin
    madd   = {1'b0, d_q[2*WIDTH-1:WIDTH]}
           + (d_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    d_step = d_q;
    case (mode_q)
      IT_SHL:  d_step = {{WIDTH{1'b0}}, d_q[WIDTH-2:0], 1'b0};
      IT_SHR:  d_step = {{WIDTH{1'b0}}, 1'b0, d_q[WIDTH-1:1]};
      IT_MUL:  d_step = {madd, d_q[WIDTH-1:1]};
      default: d_step = d_q;
    endcase
  end

  assign last      = busy_q && (cnt_q == SHW'(1));
  assign res_step  = d_step[WIDTH-1:0];
  assign hi_nz     = |d_step[2*WIDTH-1:WIDTH];
  assign cout_step = (mode_q == IT_SHL) ? d_q[WIDTH-1] : d_q[0];
  assign half_bit  = (mode_q == IT_SHL) ? d_q[HB-1] : d_q[HB];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, persistent status flags,
// iterative shift/multiply, compare, branch resolution and illegal-op report.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken,
  output logic             illegal,
  output logic             zflag,
  output logic             nflag,
  output logic             cflag,
  output logic             vflag,
  output logic             hflag,
  output logic             sflag
);

  localparam int SHW = $clog2(WIDTH) + 1;
  localparam int MSB = WIDTH - 1;
  localparam int HB  = WIDTH / 2;

  state_e                 state_q, state_d;
  logic                   run_q;
  logic [WIDTH-1:0]       result_q;
  logic [NFLAGS-1:0]      flags_q;
  logic                   taken_q, illegal_q;
  logic                   mul_q, a_msb_q;

  logic                   accept, start, commit_sc, commit_it;
  logic [WIDTH-1:0]       sc_res;
  logic [NFLAGS-1:0]      sc_flags;
  logic                   sc_taken, sc_illegal, sc_multi;
  iter_mode_e             it_mode;
  logic [SHW-1:0]         amt, it_amt;
  logic [WIDTH:0]         add_w, sub_w;
  logic [HB:0]            add_lo, sub_lo;
  logic signed [WIDTH:0]  sadd, ssub;
  logic [NFLAGS-1:0]      add_flags, sub_flags, it_flags;

  logic                   it_last, it_cout, it_half, it_hi_nz;
  logic [WIDTH-1:0]       it_res;

  function automatic logic [NFLAGS-1:0] mk_flags(input logic [WIDTH-1:0] r,
                                                 input logic c,
                                                 input logic v,
                                                 input logic h);
    logic [NFLAGS-1:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[MSB];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_H] = h;
    return f;
  endfunction

  function automatic logic [SHW-1:0] clamp_amt(input logic [SHW-1:0] raw);
    return (raw > SHW'(WIDTH)) ? SHW'(WIDTH) : raw;
  endfunction

  assign in_ready  = run_q && (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);

  // Single-cycle arithmetic; overflow taken from a sign-extended signed sum
  always_comb begin
    add_w     = {1'b0, a} + {1'b0, b};
    sub_w     = {1'b0, a} - {1'b0, b};
    add_lo    = {1'b0, a[HB-1:0]} + {1'b0, b[HB-1:0]};
    sub_lo    = {1'b0, a[HB-1:0]} - {1'b0, b[HB-1:0]};
    sadd      = $signed({a[MSB], a}) + $signed({b[MSB], b});
    ssub      = $signed({a[MSB], a}) - $signed({b[MSB], b});
    add_flags = mk_flags(add_w[WIDTH-1:0], add_w[WIDTH], sadd[WIDTH] ^ sadd[WIDTH-1], add_lo[HB]);
    sub_flags = mk_flags(sub_w[WIDTH-1:0], sub_w[WIDTH], ssub[WIDTH] ^ ssub[WIDTH-1], sub_lo[HB]);
  end

  assign amt    = clamp_amt(b[SHW-1:0]);
  assign it_amt = (op == OP_MUL) ? SHW'(WIDTH) : amt;

  always_comb begin
    sc_res     = '0;
    sc_flags   = flags_q;
    sc_taken   = 1'b0;
    sc_illegal = 1'b0;
    sc_multi   = 1'b0;
    it_mode    = IT_SHL;
    case (op)
      OP_LD:  sc_res = b;
      OP_ST:  sc_res = a;
      OP_ADD: begin sc_res = add_w[WIDTH-1:0]; sc_flags = add_flags; end
      OP_SUB: begin sc_res = sub_w[WIDTH-1:0]; sc_flags = sub_flags; end
      OP_AND: begin sc_res = a & b; sc_flags = mk_flags(a & b, 1'b0, 1'b0, 1'b0); end
      OP_OR:  begin sc_res = a | b; sc_flags = mk_flags(a | b, 1'b0, 1'b0, 1'b0); end
      OP_XOR: begin sc_res = a ^ b; sc_flags = mk_flags(a ^ b, 1'b0, 1'b0, 1'b0); end
      OP_NOT: begin sc_res = ~a;    sc_flags = mk_flags(~a, 1'b0, 1'b0, 1'b0); end
      OP_SL, OP_SR: begin
        it_mode = (op == OP_SL) ? IT_SHL : IT_SHR;
        if (amt == '0) begin
          sc_res   = a;
          sc_flags = mk_flags(a, 1'b0, 1'b0, 1'b0);
        end else begin
          sc_multi = 1'b1;
        end
      end
      OP_MUL: begin sc_multi = 1'b1; it_mode = IT_MUL; end
      OP_CMP: begin sc_res = a; sc_flags = sub_flags; end
      OP_BZ, OP_BNZ: begin
        sc_taken = (op == OP_BZ) ? flags_q[FLAG_Z] : !flags_q[FLAG_Z];
        sc_res   = sc_taken ? a : b;
      end
      OP_BRA: begin sc_res = a; sc_taken = 1'b1; end
      default: sc_illegal = 1'b1;
    endcase
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (it_mode),
    .a         (a),
    .b         (b),
    .amt       (it_amt),
    .last      (it_last),
    .res_step  (it_res),
    .cout_step (it_cout),
    .half_bit  (it_half),
    .hi_nz     (it_hi_nz)
  );

  assign it_flags = mk_flags(it_res,
                             mul_q ? it_hi_nz : it_cout,
                             mul_q ? it_hi_nz : (a_msb_q ^ it_res[MSB]),
                             mul_q ? 1'b0 : it_half);

  // FSM: state register and next-state/control decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    commit_sc = 1'b0;
    commit_it = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (sc_multi) begin
          start   = 1'b1;
          state_d = ST_EXEC;
        end else begin
          commit_sc = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_EXEC: if (it_last) begin
        commit_it = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      flags_q   <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (commit_sc) begin
      result_q  <= sc_res;
      flags_q   <= sc_flags;
      taken_q   <= sc_taken;
      illegal_q <= sc_illegal;
    end else if (commit_it) begin
      result_q  <= it_res;
      flags_q   <= it_flags;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mul_q   <= (op == OP_MUL);
      a_msb_q <= a[MSB];
    end
  end

  assign result       = result_q;
  assign branch_taken = taken_q;
  assign illegal      = illegal_q;
  assign zflag        = flags_q[FLAG_Z];
  assign nflag        = flags_q[FLAG_N];
  assign cflag        = flags_q[FLAG_C];
  assign vflag        = flags_q[FLAG_V];
  assign hflag        = flags_q[FLAG_H];
  assign sflag        = flags_q[FLAG_N] ^ flags_q[FLAG_V];

endmodule
